// File: rtl/dsp_pkg.sv
// Shared DSP constants and types used by the data-memory dump engine.
package dsp_pkg;

    localparam int DSP_DATA_WIDTH  = 16;
    localparam int DSP_DADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } dump_state_t;

    typedef struct packed {
        logic [DSP_DATA_WIDTH-1:0]  data;
        logic [DSP_DADDR_WIDTH-1:0] addr;
        logic                       last;
    } dump_entry_t;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry FIFO of stream entries; flush empties it in one cycle.
module dump_skid_fifo
    import dsp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  dump_entry_t push_entry_i,
    input  logic        pop_i,
    output dump_entry_t head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [1:0]  count_o
);

    dump_entry_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dsp_mem_dump.sv
// Sweeps a window of DSP data memory through its read port and streams each
// word, tagged with its address, on a valid/ready interface.
module dsp_mem_dump
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = DSP_DATA_WIDTH,
    parameter int ADDR_WIDTH = DSP_DADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // Stream handshake: a word moves when out_valid and out_ready are both high
    // on a rising edge; out_data/out_addr/out_last hold while valid waits on ready.

    dump_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;
    logic                  infl_last_q, infl_last_d;

    dump_entry_t push_entry;
    dump_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;
    logic        pop;
    logic        flush;
    logic        rd_en;
    logic [2:0]  occupancy;

    assign pop       = !fifo_empty && out_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    // At most two words (buffered plus in flight) are ever outstanding.
    assign rd_en     = (state_q == READ) && (occupancy < 3'd2) && (!fifo_full || pop);

    assign push_entry = '{data: mem_rd_data, addr: infl_addr_q, last: infl_last_q};

    dump_skid_fifo u_fifo (
        .clk_i        (clk),
        .rst_i        (reset),
        .flush_i      (flush),
        .push_i       (inflight_q),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = rd_en;
        infl_addr_d = infl_addr_q;
        infl_last_d = infl_last_q;
        flush       = 1'b0;
        if (rd_en) begin
            infl_addr_d = addr_q;
            infl_last_d = (remaining_q == (ADDR_WIDTH+1)'(1));
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = word_count;
                    state_d     = (word_count == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (rd_en) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the final word is accepted so done lands the next cycle.
                if (!inflight_q && (fifo_count == {1'b0, pop})) begin
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q == READ || state_q == DRAIN)) begin
            state_d    = IDLE;
            flush      = 1'b1;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            infl_last_q <= infl_last_d;
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_addr  = head.addr;
    assign out_last  = head.last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_dsp_mem_dump.sv
// Bench for dsp_mem_dump: memory model, window reference model and per-feature tests.
module tb_dsp_mem_dump;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   word_count;
    logic          abort;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    dsp_mem_dump dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .abort       (abort),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Data memory read port: one-cycle latency, garbage when not read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= DW'($urandom);
    end

    int checks = 0;
    int errors = 0;

    // Entries packed as {last, addr, data}.
    logic [AW+DW:0] exp_q[$];
    logic [AW+DW:0] obs_q[$];

    int first_valid_c, first_rd_c, done_c, done_cnt, rd_cnt;
    int stab_err, outst_err, busy_low, valid_after_abort, busy_after_abort, abort_c;

    task automatic build_expected(input logic [AW-1:0] sa, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = sa + AW'(i);
            exp_q.push_back({(i == n - 1), a, mem[a]});
        end
    endtask

    // Runs one dump and records what the stream, read port and status did.
    task automatic watch(input logic [AW-1:0] sa, input int n, input int ready_mode,
                         input int abort_after_hs, input int restart_c);
        int budget = 6 * n + 40;
        int hs_cnt = 0;
        int outst = 0;
        bit prev_stall = 0;
        bit abort_sent = 0;
        bit hs;
        logic [AW+DW:0] prev_word = '0;
        logic [AW+DW:0] word;
        first_valid_c = -1; first_rd_c = -1; done_c = -1; done_cnt = 0; rd_cnt = 0;
        stab_err = 0; outst_err = 0; busy_low = 0;
        valid_after_abort = 0; busy_after_abort = 0; abort_c = -1;
        obs_q.delete();
        build_expected(sa, n);
        @(negedge clk);
        start = 1'b1; start_addr = sa; word_count = (AW+1)'(n); abort = 1'b0; out_ready = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == restart_c);
            if (start) begin
                start_addr = sa + 8'h40;
                word_count = 9'd5;
            end
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((c % 6) == 1) || ((c % 6) == 4) || ((c % 6) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            abort = 1'b0;
            if (!abort_sent && abort_after_hs >= 0 && hs_cnt == abort_after_hs && out_valid) begin
                abort = 1'b1;
                start = 1'b1;
                abort_sent = 1;
                abort_c = c;
            end
            #1;
            word = {out_last, out_addr, out_data};
            if (mem_rd_en) begin
                if (first_rd_c < 0) first_rd_c = c;
                rd_cnt++;
            end
            if (out_valid && first_valid_c < 0) first_valid_c = c;
            if (prev_stall && (!out_valid || word !== prev_word)) stab_err++;
            hs = out_valid && out_ready;
            if (hs) begin
                obs_q.push_back(word);
                hs_cnt++;
            end
            if (outst + int'(mem_rd_en) - int'(hs) > 2) outst_err++;
            outst = outst + int'(mem_rd_en) - int'(hs);
            prev_stall = out_valid && !out_ready;
            prev_word = word;
            if (!busy && done_c < 0 && !abort_sent) busy_low++;
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (abort_sent && c > abort_c) begin
                if (out_valid) valid_after_abort++;
                if (busy) busy_after_abort++;
                if (c >= abort_c + 6) break;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_rd_en, out_valid, out_last, busy, done, mem_addr, out_data, out_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%b valid=%b last=%b busy=%b done=%b addr=%h data=%h oaddr=%h, required all 0",
                     mem_rd_en, out_valid, out_last, busy, done, mem_addr, out_data, out_addr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 256; i++) mem[i] = DW'(i * 3);
        watch(8'h10, 4, 0, -1, -1);
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d words, required 4", obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (first_rd_c != 1 || first_valid_c != 3) begin
            errors++;
            $display("FAIL basic_latency: got rd_en at %0d valid at %0d, required 1 and 3", first_rd_c, first_valid_c);
        end
        checks++;
        if (done_c != 7 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done: got cycle %0d count %0d, required cycle 7 count 1", done_c, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int run = 0; run < 4; run++) begin
            logic [AW-1:0] sa;
            int n;
            sa = (run == 0) ? 8'h10 : AW'($urandom);
            n  = (run == 0) ? 4 : $urandom_range(1, 20);
            watch(sa, n, (run == 0) ? 1 : 2, -1, -1);
            checks++;
            if (obs_q.size() != n) begin
                errors++;
                $display("FAIL bp%0d_count: got %0d words, required %0d", run, obs_q.size(), n);
            end
            for (int i = 0; i < n && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp%0d_word%0d: got %h, required %h", run, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (stab_err != 0 || outst_err != 0) begin
                errors++;
                $display("FAIL bp%0d_rules: got %0d unstable cycles and %0d over-issue cycles, required 0 and 0", run, stab_err, outst_err);
            end
            checks++;
            if (done_cnt != 1) begin
                errors++;
                $display("FAIL bp%0d_done: got %0d pulses, required 1", run, done_cnt);
            end
        end
    endtask

    task automatic test_wrap_and_empty();
        watch(8'hFE, 3, 0, -1, -1);
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d words, required 3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_c != 6) begin
            errors++;
            $display("FAIL wrap_done: got cycle %0d, required 6", done_c);
        end
        watch(AW'($urandom), 0, 0, -1, -1);
        checks++;
        if (rd_cnt != 0 || first_valid_c != -1) begin
            errors++;
            $display("FAIL empty_activity: got %0d reads first valid %0d, required 0 reads and none", rd_cnt, first_valid_c);
        end
        checks++;
        if (done_c != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL empty_done: got cycle %0d count %0d, required cycle 1 count 1", done_c, done_cnt);
        end
    endtask

    task automatic test_full_sweep();
        int bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        watch(8'h00, 256, 0, -1, -1);
        checks++;
        if (obs_q.size() != 256) begin
            errors++;
            $display("FAIL full_count: got %0d words, required 256", obs_q.size());
        end
        for (int i = 0; i < 256 && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_words: got %0d wrong words, required 0", bad);
        end
        checks++;
        if (busy_low != 0 || done_c != 259) begin
            errors++;
            $display("FAIL full_status: got %0d idle cycles done at %0d, required 0 and 259", busy_low, done_c);
        end
    endtask

    task automatic test_abort_and_restart();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        watch(8'h20, 10, 0, 2, -1);
        checks++;
        if (abort_c < 0 || valid_after_abort != 0 || busy_after_abort != 0) begin
            errors++;
            $display("FAIL abort_quiet: got abort at %0d valid cycles %0d busy cycles %0d after, required abort sent and 0 and 0",
                     abort_c, valid_after_abort, busy_after_abort);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses, required 0", done_cnt);
        end
        for (int i = 0; i < obs_q.size() && i < 10; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        watch(8'h30, 5, 2, -1, -1);
        checks++;
        if (obs_q.size() != 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_dump: got %0d words %0d done pulses, required 5 and 1", obs_q.size(), done_cnt);
        end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        @(negedge clk);
        start = 1'b1; start_addr = 8'h40; word_count = 9'd10; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_rd_en, out_valid, out_last, busy, done, mem_addr, out_data, out_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rd_en=%b valid=%b last=%b busy=%b done=%b addr=%h data=%h oaddr=%h, required all 0",
                     mem_rd_en, out_valid, out_last, busy, done, mem_addr, out_data, out_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        watch(8'h50, 6, 0, -1, -1);
        checks++;
        if (obs_q.size() != 6 || done_c != 9) begin
            errors++;
            $display("FAIL post_reset_dump: got %0d words done at %0d, required 6 and 9", obs_q.size(), done_c);
        end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL post_reset_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        watch(8'h60, 6, 1, -1, 5);
        checks++;
        if (obs_q.size() != 6 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start: got %0d words %0d done pulses, required 6 and 1", obs_q.size(), done_cnt);
        end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_start_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        word_count = '0;
        abort = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_and_empty();
        test_full_sweep();
        test_abort_and_restart();
        test_reset_mid_dump();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
